// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared encodings, FSM states and byte-lane helper for the data-memory responder.
package data_mem_pkg;
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

    function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] addrLo);
        return size == SIZE_B ? 4'b0001 << addrLo :
               size == SIZE_H ? (addrLo[1] ? 4'b1100 : 4'b0011) :
               size == SIZE_W ? 4'b1111 : 4'b0000;
    endfunction
endpackage

// File: rtl/data_mem_lane_align.sv
// data_mem_lane_align: picks the addressed byte/half out of a read word and sign/zero-extends it.
module data_mem_lane_align
    import data_mem_pkg::*;
(
    input  logic [31:0] rdWord,
    input  logic [1:0]  addrLo,
    input  logic [1:0]  size,
    input  logic        isUnsigned,
    output logic [31:0] loadData
);
    logic [31:0] wordShift;
    logic [7:0]  b;
    logic [15:0] h;

    assign wordShift = rdWord >> {addrLo, 3'b000};
    assign b = wordShift[7:0];
    assign h = addrLo[1] ? rdWord[31:16] : rdWord[15:0];
    assign loadData = size == SIZE_B ? {{24{~isUnsigned & b[7]}}, b} :
                      size == SIZE_H ? {{16{~isUnsigned & h[15]}}, h} : rdWord;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: valid/ready load/store responder over an internal word RAM
// with programmable wait states, byte lanes and load extension.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy
);
    localparam int IDX_W = $clog2(DEPTH);

    stateT              state, stateNext;
    logic [3:0]         waitCnt;
    logic [IDX_W+1:0]   addrQ, accAddr;
    logic               weQ, unsQ, errQ, accWe, accUns, accErr, reqErr, accept, doAccess;
    logic [31:0]        wdataQ, accWdata, wrData, rdWord, loadData;
    logic [1:0]         sizeQ, accSize;
    logic [3:0]         be;
    logic [IDX_W-1:0]   wordIdx;
    logic [31:0]        mem [DEPTH];

    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    assign busy       = state != IDLE;
    assign accept     = state == IDLE && req_valid;

    assign reqErr = req_size == 2'b11 || (req_size == SIZE_H && req_addr[0]) ||
                    (req_size == SIZE_W && req_addr[1:0] != 2'b00) ||
                    {2'b00, req_addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH);

    // With zero wait states the access happens on the accept edge, so use the live request.
    assign accAddr  = state == IDLE ? req_addr[IDX_W+1:0] : addrQ;
    assign accWe    = state == IDLE ? req_we : weQ;
    assign accWdata = state == IDLE ? req_wdata : wdataQ;
    assign accSize  = state == IDLE ? req_size : sizeQ;
    assign accUns   = state == IDLE ? req_unsigned : unsQ;
    assign accErr   = state == IDLE ? reqErr : errQ;
    assign doAccess = reset && ((accept && WAIT_STATES == 0) || (state == WAIT && waitCnt == 4'd0));

    assign wordIdx = accAddr[IDX_W+1:2];
    assign rdWord  = mem[wordIdx];
    assign be      = accErr ? 4'b0000 : lane_enable(accSize, accAddr[1:0]) & {4{accWe}};
    assign wrData  = accSize == SIZE_B ? {4{accWdata[7:0]}} :
                     accSize == SIZE_H ? {2{accWdata[15:0]}} : accWdata;

    data_mem_lane_align uAlign (
        .rdWord    (rdWord),
        .addrLo    (accAddr[1:0]),
        .size      (accSize),
        .isUnsigned(accUns),
        .loadData  (loadData)
    );

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (doAccess && be[i]) mem[wordIdx][8*i +: 8] <= wrData[8*i +: 8];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        if (accept) stateNext = WAIT_STATES == 0 ? RESP : WAIT;
        else if (state == WAIT && waitCnt == 4'd0) stateNext = RESP;
        else if (state == RESP && resp_ready) stateNext = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waitCnt    <= '0;
            addrQ      <= '0;
            weQ        <= 1'b0;
            wdataQ     <= '0;
            sizeQ      <= '0;
            unsQ       <= 1'b0;
            errQ       <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                addrQ   <= req_addr[IDX_W+1:0];
                weQ     <= req_we;
                wdataQ  <= req_wdata;
                sizeQ   <= req_size;
                unsQ    <= req_unsigned;
                errQ    <= reqErr;
                waitCnt <= 4'(WAIT_STATES - 1);
            end else if (state == WAIT && waitCnt != 4'd0) waitCnt <= waitCnt - 4'd1;
            if (doAccess) begin
                resp_rdata <= (accErr || accWe) ? 32'd0 : loadData;
                resp_err   <= accErr;
            end else if (state == RESP && resp_ready) begin
                resp_rdata <= '0;
                resp_err   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed load/store sequence with hand-computed expectations
// for latency, lane handling, extension, errors, back-pressure and mid-flight reset.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    int          nCmp = 0;
    int          nErr = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(256), .WAIT_STATES(2), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkReset(input string tag);
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, ".resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, ".resp_err"}, 32'(resp_err), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    // Issue one request from IDLE, check 2-wait-state latency, result, then accept it.
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                        input logic [31:0] expData, input logic expErr);
        req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".lat0"}, 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, ".lat1"}, 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, ".lat2"}, 32'(resp_valid), 32'd1);
        chk({tag, ".rdata"}, resp_rdata, expData);
        chk({tag, ".err"}, 32'(resp_err), 32'(expErr));
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk({tag, ".done"}, 32'(resp_valid), 32'd0);
        chk({tag, ".clr"}, resp_rdata, 32'd0);
    endtask

    initial begin
        #1;
        chkReset("rst0");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chkReset("rst1");

        xact("st20", 1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0, 32'h0, 1'b0);
        xact("stW", 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0);
        xact("ldW", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
        xact("stB", 1'b1, 32'h13, 32'h00000080, 2'b00, 1'b0, 32'h0, 1'b0);
        xact("ldBs", 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 32'hFFFFFF80, 1'b0);
        xact("ldBu", 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 32'h00000080, 1'b0);
        xact("ldW2", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h80ADBEEF, 1'b0);
        xact("ldB0", 1'b0, 32'h10, 32'h0, 2'b00, 1'b0, 32'hFFFFFFEF, 1'b0);
        xact("ldHs", 1'b0, 32'h12, 32'h0, 2'b01, 1'b0, 32'hFFFF80AD, 1'b0);
        xact("ldHu", 1'b0, 32'h12, 32'h0, 2'b01, 1'b1, 32'h000080AD, 1'b0);
        xact("ldH0", 1'b0, 32'h10, 32'h0, 2'b01, 1'b0, 32'hFFFFBEEF, 1'b0);
        xact("stHmis", 1'b1, 32'h11, 32'h00001234, 2'b01, 1'b0, 32'h0, 1'b1);
        xact("ldW3", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h80ADBEEF, 1'b0);
        xact("ldWmis", 1'b0, 32'h12, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
        xact("ldOOR", 1'b0, 32'h400, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
        xact("stOOR", 1'b1, 32'h3FC, 32'h55AA55AA, 2'b10, 1'b0, 32'h0, 1'b0);
        xact("ldLast", 1'b0, 32'h3FF, 32'h0, 2'b00, 1'b1, 32'h00000055, 1'b0);
        xact("sz11", 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1);

        // Back-pressure: hold resp_ready low while req_valid toggles with a conflicting store.
        req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_we = 1'b1; req_wdata = 32'h0BADF00D;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            req_valid = ~req_valid;
            chk("hold.valid", 32'(resp_valid), 32'd1);
            chk("hold.rdata", resp_rdata, 32'h80ADBEEF);
            chk("hold.ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0; req_we = 1'b0;
        chk("hold.last", resp_rdata, 32'h80ADBEEF);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("hold.done", 32'(resp_valid), 32'd0);
        xact("ldW4", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h80ADBEEF, 1'b0);

        // Reset during WAIT drops the pending store.
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_size = 2'b10;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstw.busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chkReset("rstw.a");
        repeat (3) @(posedge clk);
        #1;
        chkReset("rstw.b");
        reset = 1'b1;
        xact("ld20", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h11223344, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
